// File: rtl/operand_pkg.sv
// Shared definitions for the operand sequencer: operand width, FSM codes and
// the default debounce interval (10 ms at 50 MHz).
package operand_pkg;

   localparam int OPW              = 8;
   localparam int DEBOUNCE_DEFAULT = 500000;

   typedef enum logic [1:0] {
      LOAD_A = 2'b00,
      LOAD_B = 2'b01,
      ADD    = 2'b10,
      SHOW   = 2'b11
   } state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for one raw key level.
// Emits a single-cycle press pulse on each debounced 0->1 transition.
module key_debounce
   import operand_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = 19
) (
   input  logic Clk,
   input  logic Reset,
   input  logic raw,
   output logic press,
   output logic level
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             db;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         db    <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         press <= 1'b0;
         // Any agreement with the accepted level restarts the stability count.
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            db    <= s2;
            cnt   <= '0;
            press <= s2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign level = db;

endmodule

// File: rtl/operand_sequencer.sv
// Loads operand A then B from a shared switch bus on successive debounced
// Enter presses, then registers the 9-bit sum with carry and signed overflow.
module operand_sequencer
   import operand_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int CNT_W           = 19
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [OPW-1:0] D,
   input  logic           Enter,
   input  logic           Clear,
   output logic [OPW-1:0] A,
   output logic [OPW-1:0] B,
   output logic [OPW-1:0] Sum,
   output logic           Cout,
   output logic           Ovf,
   output logic           Valid,
   output logic [1:0]     State
);

   state_t         state, state_nxt;
   logic           press, level, accept;
   logic [OPW-1:0] a_nxt, b_nxt, sum_nxt;
   logic           cout_nxt, ovf_nxt, valid_nxt;

   // Returns {ovf, cout, sum}; overflow when like-signed operands give an unlike-signed result.
   function automatic logic [OPW+1:0] add_ovf(input logic signed [OPW-1:0] x,
                                              input logic signed [OPW-1:0] y);
      logic [OPW:0] wide;
      logic         ovf;
      wide = {1'b0, x} + {1'b0, y};
      ovf  = (x[OPW-1] == y[OPW-1]) && (wide[OPW-1] != x[OPW-1]);
      return {ovf, wide};
   endfunction

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db (
      .Clk   (Clk),
      .Reset (Reset),
      .raw   (Enter),
      .press (press),
      .level (level)
   );

   // press only ever fires while the debounced level is high
   assign accept = press & level;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= LOAD_A;
         A     <= '0;
         B     <= '0;
         Sum   <= '0;
         Cout  <= 1'b0;
         Ovf   <= 1'b0;
         Valid <= 1'b0;
      end else begin
         state <= state_nxt;
         A     <= a_nxt;
         B     <= b_nxt;
         Sum   <= sum_nxt;
         Cout  <= cout_nxt;
         Ovf   <= ovf_nxt;
         Valid <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      a_nxt     = A;
      b_nxt     = B;
      sum_nxt   = Sum;
      cout_nxt  = Cout;
      ovf_nxt   = Ovf;
      valid_nxt = Valid;
      if (Clear) begin
         state_nxt = LOAD_A;
         valid_nxt = 1'b0;
      end else begin
         case (state)
            LOAD_A, SHOW: begin
               if (accept) begin
                  a_nxt     = D;
                  b_nxt     = '0;
                  valid_nxt = 1'b0;
                  state_nxt = LOAD_B;
               end
            end
            LOAD_B: begin
               if (accept) begin
                  b_nxt     = D;
                  state_nxt = ADD;
               end
            end
            ADD: begin
               {ovf_nxt, cout_nxt, sum_nxt} = add_ovf(A, B);
               valid_nxt = 1'b1;
               state_nxt = SHOW;
            end
            default: state_nxt = LOAD_A;
         endcase
      end
   end

   assign State = state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a cycle-level reference model and
// hand-computed spot checks (DEBOUNCE_CYCLES = 4).
module tb_operand_sequencer;

   localparam int DB = 4;

   logic       Clk = 1'b0;
   logic       Reset, Enter, Clear;
   logic [7:0] D;
   logic [7:0] A, B, Sum;
   logic       Cout, Ovf, Valid;
   logic [1:0] State;

   int n_cmp  = 0;
   int n_fail = 0;

   operand_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .D     (D),
      .Enter (Enter),
      .Clear (Clear),
      .A     (A),
      .B     (B),
      .Sum   (Sum),
      .Cout  (Cout),
      .Ovf   (Ovf),
      .Valid (Valid),
      .State (State)
   );

   always #5 Clk = ~Clk;

   // Reference model: key path as "s2 disagrees with accepted level for DB edges in a row".
   logic       m_s1, m_s2, m_db, m_press;
   int         m_run;
   logic [1:0] m_state;
   logic [7:0] mA, mB, mSum;
   logic       mCout, mOvf, mValid;
   bit         started = 0;

   always @(posedge Clk) begin : model
      int   tot;
      int   st;
      logic npress;
      if (Reset) begin
         m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0; m_run = 0;
         m_state = 2'd0; mA = 0; mB = 0; mSum = 0; mCout = 0; mOvf = 0; mValid = 0;
         started = 1;
      end else begin
         if (Clear) begin
            m_state = 2'd0;
            mValid  = 0;
         end else if ((m_state == 2'd0 || m_state == 2'd3) && m_press) begin
            mA = D; mB = 8'h00; mValid = 0; m_state = 2'd1;
         end else if (m_state == 2'd1 && m_press) begin
            mB = D; m_state = 2'd2;
         end else if (m_state == 2'd2) begin
            tot    = int'(mA) + int'(mB);
            mSum   = tot[7:0];
            mCout  = (tot > 255);
            st     = int'($signed(mA)) + int'($signed(mB));
            mOvf   = (st > 127) || (st < -128);
            mValid = 1;
            m_state = 2'd3;
         end
         npress = 0;
         if (m_s2 != m_db) begin
            m_run = m_run + 1;
            if (m_run == DB) begin
               m_db   = m_s2;
               m_run  = 0;
               npress = m_s2;
            end
         end else begin
            m_run = 0;
         end
         m_s2    = m_s1;
         m_s1    = Enter;
         m_press = npress;
      end
   end

   always @(negedge Clk) begin
      if (started) begin
         n_cmp++;
         if ({A, B, Sum, Cout, Ovf, Valid, State} !== {mA, mB, mSum, mCout, mOvf, mValid, m_state}) begin
            n_fail++;
            $display("FAIL model t=%0t got A=%h B=%h Sum=%h C=%b V=%b Valid=%b State=%b, expected A=%h B=%h Sum=%h C=%b V=%b Valid=%b State=%b",
                     $time, A, B, Sum, Cout, Ovf, Valid, State, mA, mB, mSum, mCout, mOvf, mValid, m_state);
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic press_key(input logic [7:0] d);
      D = d;
      Enter = 1'b1;
      repeat (8) step();
      Enter = 1'b0;
      repeat (8) step();
   endtask

   // Loads a then b; checks B at +7 (ADD) and the registered result at +8.
   task automatic run_pair(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] s, input logic c, input logic o);
      press_key(a);
      chk({name, " A"}, 32'(A), 32'(a));
      D = b;
      Enter = 1'b1;
      repeat (7) step();
      chk({name, " B/state@ADD"}, {22'd0, B, State}, {22'd0, b, 2'b10});
      step();
      chk({name, " result"}, {19'd0, Sum, Cout, Ovf, Valid, State},
          {19'd0, s, c, o, 1'b1, 2'b11});
      Enter = 1'b0;
      repeat (8) step();
   endtask

   initial begin
      Reset = 1'b1; Enter = 1'b0; Clear = 1'b0; D = 8'h00;
      repeat (3) step();
      chk("reset outputs", {A, B, Sum, Cout, Ovf, Valid, State}, 32'd0);
      Reset = 1'b0;
      step();

      run_pair("3A+25", 8'h3A, 8'h25, 8'h5F, 1'b0, 1'b0);
      run_pair("FF+01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      run_pair("7F+01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
      run_pair("80+80", 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

      // Bounce 1,0,1,0 then a clean hold: one press 6 cycles after the final rise.
      Clear = 1'b1; step(); Clear = 1'b0;
      chk("clear from SHOW", 32'(State), 32'd0);
      D = 8'h5C;
      Enter = 1'b1; step(); Enter = 1'b0; step();
      Enter = 1'b1; step(); Enter = 1'b0; step();
      Enter = 1'b1;
      repeat (6) step();
      chk("bounce state before accept", 32'(State), 32'd0);
      step();
      chk("bounce accepted", {22'd0, A, State}, {22'd0, 8'h5C, 2'b01});
      repeat (13) step();
      chk("bounce single press", 32'(State), 32'd1);
      Enter = 1'b0;
      repeat (8) step();

      // Long hold gives one press; the next press after release loads B.
      Clear = 1'b1; step(); Clear = 1'b0;
      D = 8'h11;
      Enter = 1'b1;
      repeat (100) step();
      chk("held key one press", {22'd0, A, State}, {22'd0, 8'h11, 2'b01});
      Enter = 1'b0;
      repeat (10) step();
      D = 8'h22;
      Enter = 1'b1;
      repeat (7) step();
      chk("second press loads B", {22'd0, B, State}, {22'd0, 8'h22, 2'b10});
      step();
      chk("11+22 sum", {22'd0, Sum, Valid, Cout}, {22'd0, 8'h33, 1'b1, 1'b0});
      Enter = 1'b0;
      repeat (8) step();

      // Press in SHOW starts a new pair.
      D = 8'h10;
      Enter = 1'b1;
      repeat (7) step();
      chk("SHOW press", {13'd0, A, B, Valid, State}, {13'd0, 8'h10, 8'h00, 1'b0, 2'b01});
      Enter = 1'b0;
      repeat (8) step();

      Clear = 1'b1; step(); Clear = 1'b0;
      chk("clear in LOAD_B", {13'd0, Sum, A, Valid, State}, {13'd0, 8'h33, 8'h10, 1'b0, 2'b00});

      press_key(8'h44);
      D = 8'h55;
      Enter = 1'b1;
      repeat (7) step();
      chk("reached ADD", 32'(State), 32'd2);
      Clear = 1'b1; step(); Clear = 1'b0;
      chk("clear in ADD", {21'd0, Sum, Valid, State}, {21'd0, 8'h33, 1'b0, 2'b00});
      Enter = 1'b0;
      repeat (8) step();

      // Reset during a partial debounce with the key held.
      D = 8'h66;
      Enter = 1'b1;
      repeat (3) step();
      Reset = 1'b1;
      repeat (2) step();
      chk("reset mid-debounce", {A, B, Sum, Cout, Ovf, Valid, State}, 32'd0);
      Reset = 1'b0;
      repeat (6) step();
      chk("post-reset before accept", 32'(State), 32'd0);
      step();
      chk("post-reset press", {22'd0, A, State}, {22'd0, 8'h66, 2'b01});
      Enter = 1'b0;
      repeat (10) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
